// File: rtl/spec_mag_compress.sv
// spec_mag_compress: turns complex FFT bins into 10-bit spectrogram colour indices, forwards
// the lower half-spectrum with its bin address, and tracks frames and spectrogram columns.
// Build option: define SPEC_LOG_SCALE_EN for log2 compression; otherwise linear shift+saturate.
module spec_mag_compress #(
  parameter int unsigned COMP_W    = 27,
  parameter int unsigned NFFT      = 1024,
  parameter int unsigned KEEP_BINS = 512,
  parameter int unsigned COL_NUM   = 140,
  parameter int unsigned LIN_SHIFT = 8
) (
  input  logic        i_aclk,
  input  logic        rst,
  input  logic [63:0] i_axi4s_data_tdata,
  input  logic [9:0]  i_axi4s_data_tuser,
  input  logic        i_axi4s_data_tvalid,
  input  logic        i_axi4s_data_tlast,
  input  logic        i_enable,
  output logic [9:0]  o_mag_tdata,
  output logic [8:0]  o_mag_tuser,
  output logic        o_mag_tvalid,
  output logic        o_frame_done,
  output logic [7:0]  o_col_cnt,
  output logic        o_seq_err
);

  localparam int unsigned AbsW = COMP_W - 1;

  typedef enum logic [0:0] {StSync, StRun} state_e;

  state_e      state_q;
  logic [10:0] exp_bin_q;   // one bit wider than tuser so bin NFFT-1 without tlast never re-matches 0
  logic        seq_err_q;

  // Beat classification against the frame state
  logic [10:0] bin;
  logic        is_last_bin, tlast_ok, beat_sync, beat_run, bin_match, good, bad;

  assign bin         = {1'b0, i_axi4s_data_tuser};
  assign is_last_bin = (bin == 11'(NFFT - 1));
  assign tlast_ok    = !i_axi4s_data_tlast || is_last_bin;
  assign beat_sync   = (state_q == StSync) && i_axi4s_data_tvalid && i_enable && (bin == '0);
  assign beat_run    = (state_q == StRun) && i_axi4s_data_tvalid && i_enable;
  assign bin_match   = beat_sync || (beat_run && (bin == exp_bin_q));
  assign good        = bin_match && tlast_ok;
  assign bad         = (beat_sync || beat_run) && !good;

  logic unused_tdata;
  assign unused_tdata = ^{i_axi4s_data_tdata[31:COMP_W], i_axi4s_data_tdata[63:32+COMP_W]};

  // Pipeline registers
  logic                fwd0_q, done0_q, fwd1_q, done1_q, fwd2_q, done2_q, fwd3_q, done3_q;
  logic [8:0]          addr0_q, addr1_q, addr2_q, addr3_q;
  logic [COMP_W-1:0]   re0_q, im0_q;
  logic [AbsW-1:0]     abs_re1_q, abs_im1_q, mx2_q, mn2_q;
  logic [COMP_W-1:0]   mag3_q;
  logic [7:0]          col_cnt_q;
  logic [9:0]          comp;

  // Two's-complement magnitude; the most negative code saturates to the largest positive one
  function automatic logic [AbsW-1:0] sat_abs(input logic [COMP_W-1:0] x);
    logic [COMP_W-1:0] neg;
    neg = ~x + 1'b1;
    if (!x[COMP_W-1]) return x[AbsW-1:0];
    else if (neg[COMP_W-1]) return '1;
    else return neg[AbsW-1:0];
  endfunction

  // Frame FSM: sync on bin 0, check bin sequence, launch accepted beats into the pipeline
  always_ff @(posedge i_aclk) begin
    if (rst) begin
      state_q   <= StSync;
      exp_bin_q <= '0;
      seq_err_q <= 1'b0;
      fwd0_q    <= 1'b0;
      done0_q   <= 1'b0;
    end else begin
      fwd0_q  <= good && (bin < 11'(KEEP_BINS));
      done0_q <= good && i_axi4s_data_tlast;
      if (bad) seq_err_q <= 1'b1;
      case (state_q)
        StSync: begin
          if (good && !i_axi4s_data_tlast) begin
            state_q   <= StRun;
            exp_bin_q <= 11'd1;
          end
        end
        StRun: begin
          if (!i_enable || bad || (good && i_axi4s_data_tlast)) state_q <= StSync;
          else if (good) exp_bin_q <= exp_bin_q + 11'd1;
        end
        default: state_q <= StSync;
      endcase
    end
  end

  // Datapath stages; data needs no reset because the flags qualify it
  always_ff @(posedge i_aclk) begin
    re0_q     <= i_axi4s_data_tdata[COMP_W-1:0];
    im0_q     <= i_axi4s_data_tdata[32 +: COMP_W];
    addr0_q   <= i_axi4s_data_tuser[8:0];
    abs_re1_q <= sat_abs(re0_q);
    abs_im1_q <= sat_abs(im0_q);
    addr1_q   <= addr0_q;
    mx2_q     <= (abs_re1_q > abs_im1_q) ? abs_re1_q : abs_im1_q;
    mn2_q     <= (abs_re1_q > abs_im1_q) ? abs_im1_q : abs_re1_q;
    addr2_q   <= addr1_q;
    mag3_q    <= {1'b0, mx2_q} + {3'b0, mn2_q[AbsW-1:2]} + {4'b0, mn2_q[AbsW-1:3]};
    addr3_q   <= addr2_q;
  end

  // Flag pipeline, output register and column counter
  always_ff @(posedge i_aclk) begin
    if (rst) begin
      fwd1_q       <= 1'b0;
      done1_q      <= 1'b0;
      fwd2_q       <= 1'b0;
      done2_q      <= 1'b0;
      fwd3_q       <= 1'b0;
      done3_q      <= 1'b0;
      o_mag_tvalid <= 1'b0;
      o_mag_tdata  <= '0;
      o_mag_tuser  <= '0;
      o_frame_done <= 1'b0;
      col_cnt_q    <= '0;
    end else begin
      fwd1_q       <= fwd0_q;
      done1_q      <= done0_q;
      fwd2_q       <= fwd1_q;
      done2_q      <= done1_q;
      fwd3_q       <= fwd2_q;
      done3_q      <= done2_q;
      o_mag_tvalid <= fwd3_q;
      o_mag_tdata  <= comp;
      o_mag_tuser  <= addr3_q;
      o_frame_done <= done3_q;
      if (done3_q) col_cnt_q <= (col_cnt_q == 8'(COL_NUM - 1)) ? 8'd0 : col_cnt_q + 8'd1;
    end
  end

`ifdef SPEC_LOG_SCALE_EN
  // Log compression: leading-one position, then the five bits just below it
  always_comb begin
    logic [4:0]        p;
    logic [COMP_W+4:0] ext;
    p = '0;
    for (int i = 0; i < COMP_W; i++) begin
      if (mag3_q[i]) p = 5'(i);
    end
    if (p >= 5'd5) ext = {5'b0, mag3_q} >> (p - 5'd5);
    else           ext = {5'b0, mag3_q} << (5'd5 - p);
    comp = (mag3_q == '0) ? 10'd0 : {p, ext[4:0]};
  end
`else
  logic [COMP_W-1:0] lin;
  assign lin = mag3_q >> LIN_SHIFT;

  // Linear compression with saturation to the top colour index
  always_comb begin
    comp = (|lin[COMP_W-1:10]) ? 10'h3ff : lin[9:0];
  end
`endif

  assign o_col_cnt = col_cnt_q;
  assign o_seq_err = seq_err_q;

endmodule

// File: tb/tb_spec_mag_compress.sv
// tb_spec_mag_compress: scoreboard bench for spec_mag_compress (linear or SPEC_LOG_SCALE_EN build).
module tb_spec_mag_compress;

  localparam int COMP_W    = 27;
  localparam int NFFT      = 1024;
  localparam int KEEP_BINS = 512;
  localparam int COL_NUM   = 6;   // small column ring so the wrap is reached in a few frames
  localparam int LIN_SHIFT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [9:0]  tuser;
  logic        tvalid, tlast, enable;
  logic [9:0]  o_mag_tdata;
  logic [8:0]  o_mag_tuser;
  logic        o_mag_tvalid, o_frame_done, o_seq_err;
  logic [7:0]  o_col_cnt;

  always #5 clk = ~clk;

  spec_mag_compress #(
    .COMP_W   (COMP_W),
    .NFFT     (NFFT),
    .KEEP_BINS(KEEP_BINS),
    .COL_NUM  (COL_NUM),
    .LIN_SHIFT(LIN_SHIFT)
  ) dut (
    .i_aclk             (clk),
    .rst                (rst),
    .i_axi4s_data_tdata (tdata),
    .i_axi4s_data_tuser (tuser),
    .i_axi4s_data_tvalid(tvalid),
    .i_axi4s_data_tlast (tlast),
    .i_enable           (enable),
    .o_mag_tdata        (o_mag_tdata),
    .o_mag_tuser        (o_mag_tuser),
    .o_mag_tvalid       (o_mag_tvalid),
    .o_frame_done       (o_frame_done),
    .o_col_cnt          (o_col_cnt),
    .o_seq_err          (o_seq_err)
  );

  typedef struct { int cyc; int addr; int data; } beat_t;
  typedef struct { int cyc; int col; } done_t;

  beat_t exp_q[$];
  done_t done_q[$];
  int    cyc       = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    col_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint sat_abs(input longint v);
    longint lim;
    longint a;
    lim = (longint'(1) << (COMP_W - 1)) - 1;
    a   = (v < 0) ? -v : v;
    return (a > lim) ? lim : a;
  endfunction

  // Reference magnitude + compression
  function automatic int model_out(input longint re, input longint im);
    longint ar, ai, mx, mn, mag;
    int     p;
    ar  = sat_abs(re);
    ai  = sat_abs(im);
    mx  = (ar > ai) ? ar : ai;
    mn  = (ar > ai) ? ai : ar;
    mag = mx + (mn >> 2) + (mn >> 3);
    p   = 0;
`ifdef SPEC_LOG_SCALE_EN
    if (mag == 0) return 0;
    for (int i = 0; i < COMP_W; i++) if (mag[i]) p = i;
    if (p >= 5) return p * 32 + int'((mag >> (p - 5)) & 31);
    else        return p * 32 + int'((mag << (5 - p)) & 31);
`else
    mag = mag >> LIN_SHIFT;
    return (mag > 1023) ? 1023 : int'(mag) + p;
`endif
  endfunction

  function automatic longint rand_comp();
    longint v;
    v = longint'($urandom_range(0, (1 << COMP_W) - 1)) - (longint'(1) << (COMP_W - 1));
    return v >>> $urandom_range(0, COMP_W - 1);
  endfunction

  // Drive one beat; fwd pushes an expected output, ends pushes an expected frame-done
  task automatic send_beat(input longint re, input longint im, input int bin, input bit last,
                           input bit fwd, input bit ends, input int want);
    logic [63:0] d;
    logic [COMP_W-1:0] rb, ib;
    d  = {$urandom, $urandom};
    rb = re[COMP_W-1:0];
    ib = im[COMP_W-1:0];
    d[COMP_W-1:0]    = rb;
    d[32 +: COMP_W]  = ib;
    tdata  = d;
    tuser  = 10'(bin);
    tvalid = 1'b1;
    tlast  = last;
    if (fwd) exp_q.push_back('{cyc + 5, bin, (want < 0) ? model_out(re, im) : want});
    if (ends) begin
      col_model = (col_model + 1) % COL_NUM;
      done_q.push_back('{cyc + 5, col_model});
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: ramp re=k<<8, im=0; mode 1: random components
  task automatic good_frame(input int mode);
    for (int k = 0; k < NFFT; k++) begin
      if (mode == 0) send_beat(longint'(k) << 8, 0, k, k == NFFT - 1, k < KEEP_BINS,
                               k == NFFT - 1, -1);
      else           send_beat(rand_comp(), rand_comp(), k, k == NFFT - 1, k < KEEP_BINS,
                               k == NFFT - 1, -1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_tvalid"}, o_mag_tvalid, 0);
    check_eq({tag, "_tdata"}, o_mag_tdata, 0);
    check_eq({tag, "_tuser"}, o_mag_tuser, 0);
    check_eq({tag, "_frame_done"}, o_frame_done, 0);
    check_eq({tag, "_col_cnt"}, o_col_cnt, 0);
    check_eq({tag, "_seq_err"}, o_seq_err, 0);
  endtask

  // Output monitor: pops the scoreboard on every output beat / frame-done pulse
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      b = exp_q.pop_front();
      check_eq("missed_out_cycle", cyc, b.cyc);
    end
    while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
      d = done_q.pop_front();
      check_eq("missed_done_cycle", cyc, d.cyc);
    end
    if (o_mag_tvalid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("extra_out", o_mag_tvalid, 0);
      else begin
        b = exp_q.pop_front();
        check_eq("out_cycle", cyc, b.cyc);
        check_eq("out_addr", o_mag_tuser, b.addr);
        check_eq("out_data", o_mag_tdata, b.data);
      end
    end
    if (o_frame_done === 1'b1) begin
      if (done_q.size() == 0) check_eq("extra_done", o_frame_done, 0);
      else begin
        d = done_q.pop_front();
        check_eq("done_cycle", cyc, d.cyc);
        check_eq("done_col_cnt", o_col_cnt, d.col);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    tuser  = '0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Linear ramp frame
    good_frame(0);
    idle(8);
    check_eq("col_after_first", o_col_cnt, 1);

    // Magnitude corner cases at bins 0..2, random elsewhere
    for (int k = 0; k < NFFT; k++) begin
      bit last;
      last = (k == NFFT - 1);
`ifdef SPEC_LOG_SCALE_EN
      if (k == 0)      send_beat(-(longint'(1) << 26), 0, k, last, 1'b1, last, 25 * 32 + 31);
      else if (k == 2) send_beat(3000, -4000, k, last, 1'b1, last, 12 * 32 + 8);
`else
      if (k == 0)      send_beat(-(longint'(1) << 26), 0, k, last, 1'b1, last, 1023);
      else if (k == 2) send_beat(3000, -4000, k, last, 1'b1, last, 20);
`endif
      else if (k == 1) send_beat(0, 0, k, last, 1'b1, last, 0);
      else send_beat(rand_comp(), rand_comp(), k, last, k < KEEP_BINS, last, -1);
    end

    // Back-to-back frames through the column wrap
    repeat (COL_NUM + 1) good_frame(1);
    idle(8);
    check_eq("col_after_wrap", o_col_cnt, col_model);

    // Sequence error: bin 100 skipped
    check_eq("seq_err_clear", o_seq_err, 0);
    for (int k = 0; k < 100; k++) send_beat(rand_comp(), rand_comp(), k, 1'b0, 1'b1, 1'b0, -1);
    send_beat(rand_comp(), rand_comp(), 101, 1'b0, 1'b0, 1'b0, -1);
    check_eq("seq_err_set", o_seq_err, 1);
    idle(8);
    check_eq("col_after_seq_err", o_col_cnt, col_model);
    good_frame(1);
    idle(8);
    check_eq("seq_err_sticky", o_seq_err, 1);

    // Enable abort at bin 300
    for (int k = 0; k < 300; k++) send_beat(rand_comp(), rand_comp(), k, 1'b0, 1'b1, 1'b0, -1);
    enable = 1'b0;
    for (int k = 300; k < 306; k++) send_beat(rand_comp(), rand_comp(), k, 1'b0, 1'b0, 1'b0, -1);
    enable = 1'b1;
    for (int k = 306; k < 311; k++) send_beat(rand_comp(), rand_comp(), k, 1'b0, 1'b0, 1'b0, -1);
    idle(8);
    check_eq("col_after_abort", o_col_cnt, col_model);
    good_frame(0);
    idle(2);

    // Reset at bin 200
    for (int k = 0; k < 200; k++) send_beat(rand_comp(), rand_comp(), k, 1'b0, 1'b1, 1'b0, -1);
    tdata  = {$urandom, $urandom};
    tuser  = 10'd200;
    tvalid = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    done_q.delete();
    col_model = 0;
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    for (int k = 201; k < 211; k++) send_beat(rand_comp(), rand_comp(), k, 1'b0, 1'b0, 1'b0, -1);
    good_frame(0);
    idle(8);
    check_eq("col_after_reset_frame", o_col_cnt, 1);
    check_eq("seq_err_after_reset", o_seq_err, 0);

    check_eq("scoreboard_left", exp_q.size(), 0);
    check_eq("done_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
